// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative RV32M multiply/divide unit sitting behind the execute stage.
// Multiply is shift-add and divide is restoring, one bit per cycle on operand
// magnitudes. Signs are fixed up at the end. EX stalls until the done pulse.
module mul_div_unit #(
  parameter int XLEN      = 32,
  parameter bit EARLY_OUT = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush_i,
  input  logic            start_i,
  input  logic [2:0]      ctrl_i,
  input  logic [XLEN-1:0] src1_i,
  input  logic [XLEN-1:0] src2_i,
  output logic [XLEN-1:0] result_o,
  output logic            done_o,
  output logic            busy_o
);

  localparam int CW = $clog2(XLEN);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       count_q, count_d;
  logic [2:0]          ctrl_q, ctrl_d;
  logic                neg_q, neg_d;
  logic                neg_a_q, neg_a_d;
  logic                special_q, special_d;
  logic [XLEN-1:0]     spec_res_q, spec_res_d;
  logic [2*XLEN-1:0]   prod_q, prod_d;
  logic [2*XLEN-1:0]   mcand_q, mcand_d;
  logic [XLEN-1:0]     opb_q, opb_d;
  logic [XLEN:0]       rem_q, rem_d;
  logic [XLEN-1:0]     quo_q, quo_d;
  logic [XLEN-1:0]     result_q, result_d;

  logic                a_signed, b_signed;
  logic                neg_a, neg_b;
  logic [XLEN-1:0]     mag_a, mag_b;
  logic                div_zero, div_ovf, special;
  logic [XLEN-1:0]     spec_res;

  logic [2*XLEN-1:0]   prod_step, prod_fin;
  logic [XLEN:0]       rem_shift, rem_step;
  logic                rem_ge;
  logic [XLEN-1:0]     quo_step, quo_fin, rem_fin;
  logic [XLEN-1:0]     final_res;

  // Decode the incoming operation: operand signedness, magnitudes and the
  // divide special cases whose answers are known without iterating.
  always_comb begin
    a_signed = 1'b0;
    b_signed = 1'b0;
    case (ctrl_i)
      3'd0, 3'd1, 3'd4, 3'd6: begin
        a_signed = 1'b1;
        b_signed = 1'b1;
      end
      3'd2: a_signed = 1'b1;
      default: ;
    endcase
    neg_a    = a_signed & src1_i[XLEN-1];
    neg_b    = b_signed & src2_i[XLEN-1];
    mag_a    = neg_a ? -src1_i : src1_i;
    mag_b    = neg_b ? -src2_i : src2_i;
    div_zero = (src2_i == '0);
    div_ovf  = a_signed && (src1_i == {1'b1, {(XLEN-1){1'b0}}}) && (src2_i == '1);
    special  = ctrl_i[2] & (div_zero | div_ovf);
    if (div_zero)
      spec_res = ctrl_i[1] ? src1_i : '1;
    else
      spec_res = ctrl_i[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
  end

  // One datapath step for both algorithms plus the sign-corrected result that
  // the last step produces.
  always_comb begin
    prod_step = opb_q[0] ? (prod_q + mcand_q) : prod_q;
    rem_shift = {rem_q[XLEN-1:0], quo_q[XLEN-1]};
    rem_ge    = rem_q[XLEN] | (rem_shift >= {1'b0, opb_q});
    rem_step  = rem_ge ? (rem_shift - {1'b0, opb_q}) : rem_shift;
    quo_step  = {quo_q[XLEN-2:0], rem_ge};
    prod_fin  = neg_q ? -prod_step : prod_step;
    quo_fin   = neg_q ? -quo_step : quo_step;
    rem_fin   = neg_a_q ? -rem_step[XLEN-1:0] : rem_step[XLEN-1:0];
    if (special_q)
      final_res = spec_res_q;
    else if (ctrl_q[2])
      final_res = ctrl_q[1] ? rem_fin : quo_fin;
    else if (ctrl_q[1:0] == 2'd0)
      final_res = prod_fin[XLEN-1:0];
    else
      final_res = prod_fin[2*XLEN-1:XLEN];
  end

  // Next-state logic: accept a start in IDLE, iterate in BUSY, pulse in DONE;
  // a flush always returns to IDLE and leaves the visible result untouched.
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    ctrl_d     = ctrl_q;
    neg_d      = neg_q;
    neg_a_d    = neg_a_q;
    special_d  = special_q;
    spec_res_d = spec_res_q;
    prod_d     = prod_q;
    mcand_d    = mcand_q;
    opb_d      = opb_q;
    rem_d      = rem_q;
    quo_d      = quo_q;
    result_d   = result_q;
    case (state_q)
      IDLE: begin
        if (start_i && !flush_i) begin
          ctrl_d     = ctrl_i;
          neg_d      = neg_a ^ neg_b;
          neg_a_d    = neg_a;
          special_d  = special;
          spec_res_d = spec_res;
          prod_d     = '0;
          mcand_d    = {{XLEN{1'b0}}, mag_a};
          opb_d      = mag_b;
          rem_d      = '0;
          quo_d      = mag_a;
          count_d    = CW'(XLEN-1);
          if (EARLY_OUT && special) begin
            state_d  = DONE;
            result_d = spec_res;
          end else begin
            state_d  = BUSY;
          end
        end
      end
      BUSY: begin
        if (ctrl_q[2]) begin
          rem_d = rem_step;
          quo_d = quo_step;
        end else begin
          prod_d  = prod_step;
          mcand_d = {mcand_q[2*XLEN-2:0], 1'b0};
          opb_d   = {1'b0, opb_q[XLEN-1:1]};
        end
        count_d = count_q - CW'(1);
        if (count_q == '0) begin
          state_d  = DONE;
          result_d = final_res;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (flush_i) begin
      state_d  = IDLE;
      result_d = result_q;
    end
  end

  // State and datapath registers, cleared by the asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      count_q    <= '0;
      ctrl_q     <= '0;
      neg_q      <= 1'b0;
      neg_a_q    <= 1'b0;
      special_q  <= 1'b0;
      spec_res_q <= '0;
      prod_q     <= '0;
      mcand_q    <= '0;
      opb_q      <= '0;
      rem_q      <= '0;
      quo_q      <= '0;
      result_q   <= '0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      ctrl_q     <= ctrl_d;
      neg_q      <= neg_d;
      neg_a_q    <= neg_a_d;
      special_q  <= special_d;
      spec_res_q <= spec_res_d;
      prod_q     <= prod_d;
      mcand_q    <= mcand_d;
      opb_q      <= opb_d;
      rem_q      <= rem_d;
      quo_q      <= quo_d;
      result_q   <= result_d;
    end
  end

  assign result_o = result_q;
  assign done_o   = (state_q == DONE);
  assign busy_o   = (state_q != IDLE);

endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit: runs an early-out and a full-latency instance side by side
// against a cycle-level behavioural model built from plain arithmetic.
module tb_mul_div_unit;

  logic        clk     = 1'b0;
  logic        rst_n   = 1'b1;
  logic        flush_i = 1'b0;
  logic        start_i = 1'b0;
  logic [2:0]  ctrl_i  = 3'd0;
  logic [31:0] src1_i  = 32'd0;
  logic [31:0] src2_i  = 32'd0;

  logic [31:0] res_e, res_f;
  logic        done_e, done_f, busy_e, busy_f;

  int total = 0;
  int bad   = 0;

  // model per instance: index 0 = early-out, index 1 = full latency
  int          m_state [2];
  int          m_left  [2];
  logic [31:0] m_pend  [2];
  logic [31:0] m_out   [2];

  logic        s_done  [2];
  logic        s_busy  [2];
  logic [31:0] s_res   [2];

  // free-running 10 ns clock
  always #5 clk = ~clk;

  mul_div_unit #(.XLEN(32), .EARLY_OUT(1'b1)) dut_early (
    .clk(clk), .rst_n(rst_n), .flush_i(flush_i), .start_i(start_i),
    .ctrl_i(ctrl_i), .src1_i(src1_i), .src2_i(src2_i),
    .result_o(res_e), .done_o(done_e), .busy_o(busy_e)
  );

  mul_div_unit #(.XLEN(32), .EARLY_OUT(1'b0)) dut_full (
    .clk(clk), .rst_n(rst_n), .flush_i(flush_i), .start_i(start_i),
    .ctrl_i(ctrl_i), .src1_i(src1_i), .src2_i(src2_i),
    .result_o(res_f), .done_o(done_f), .busy_o(busy_f)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  // architectural RV32M result from plain integer arithmetic
  function automatic logic [31:0] refResult(input logic [2:0] c, input logic [31:0] a,
                                            input logic [31:0] b);
    int          sa, sb, sr;
    longint      p;
    logic [63:0] u, ua, ub;
    logic [31:0] r;
    sa = a;
    sb = b;
    ua = {32'd0, a};
    ub = {32'd0, b};
    r  = 32'd0;
    case (c)
      3'd0: begin p = longint'(sa) * longint'(sb); r = p[31:0];  end
      3'd1: begin p = longint'(sa) * longint'(sb); r = p[63:32]; end
      3'd2: begin p = longint'(sa) * longint'(ub); r = p[63:32]; end
      3'd3: begin u = ua * ub; r = u[63:32]; end
      3'd4: begin
        if (b == 32'd0) r = 32'hFFFFFFFF;
        else if (a == 32'h80000000 && b == 32'hFFFFFFFF) r = 32'h80000000;
        else begin sr = sa / sb; r = sr; end
      end
      3'd5: r = (b == 32'd0) ? 32'hFFFFFFFF : a / b;
      3'd6: begin
        if (b == 32'd0) r = a;
        else if (a == 32'h80000000 && b == 32'hFFFFFFFF) r = 32'd0;
        else begin sr = sa % sb; r = sr; end
      end
      default: r = (b == 32'd0) ? a : a % b;
    endcase
    return r;
  endfunction

  function automatic bit isEarly(input logic [2:0] c, input logic [31:0] a,
                                 input logic [31:0] b);
    return c[2] && ((b == 32'd0) ||
                    (!c[0] && a == 32'h80000000 && b == 32'hFFFFFFFF));
  endfunction

  // advance the model across the coming rising edge
  task automatic modelStep(input bit st, input bit fl, input logic [2:0] c,
                           input logic [31:0] a, input logic [31:0] b);
    for (int i = 0; i < 2; i++) begin
      if (fl) m_state[i] = 0;
      else begin
        case (m_state[i])
          0: if (st) begin
            if (i == 0 && isEarly(c, a, b)) begin
              m_state[i] = 2;
              m_out[i]   = refResult(c, a, b);
            end else begin
              m_state[i] = 1;
              m_left[i]  = 32;
              m_pend[i]  = refResult(c, a, b);
            end
          end
          1: begin
            m_left[i]--;
            if (m_left[i] == 0) begin
              m_state[i] = 2;
              m_out[i]   = m_pend[i];
            end
          end
          default: m_state[i] = 0;
        endcase
      end
    end
  endtask

  // one cycle: sample and check outputs mid-cycle, then drive the next inputs
  task automatic applyStimulus(input bit st, input bit fl, input logic [2:0] c,
                               input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    s_done[0] = done_e; s_busy[0] = busy_e; s_res[0] = res_e;
    s_done[1] = done_f; s_busy[1] = busy_f; s_res[1] = res_f;
    checkOutput("done_early", {31'd0, s_done[0]}, {31'd0, m_state[0] == 2});
    checkOutput("busy_early", {31'd0, s_busy[0]}, {31'd0, m_state[0] != 0});
    checkOutput("res_early",  s_res[0], m_out[0]);
    checkOutput("done_full",  {31'd0, s_done[1]}, {31'd0, m_state[1] == 2});
    checkOutput("busy_full",  {31'd0, s_busy[1]}, {31'd0, m_state[1] != 0});
    checkOutput("res_full",   s_res[1], m_out[1]);
    start_i = st;
    flush_i = fl;
    ctrl_i  = c;
    src1_i  = a;
    src2_i  = b;
    modelStep(st, fl, c, a, b);
  endtask

  // asynchronous reset asserted between clock edges
  task automatic doReset();
    @(posedge clk);
    #2 rst_n = 1'b0;
    start_i = 1'b0;
    flush_i = 1'b0;
    #1;
    checkOutput("rst_done_e", {31'd0, done_e}, 32'd0);
    checkOutput("rst_busy_e", {31'd0, busy_e}, 32'd0);
    checkOutput("rst_res_e",  res_e, 32'd0);
    checkOutput("rst_done_f", {31'd0, done_f}, 32'd0);
    checkOutput("rst_busy_f", {31'd0, busy_f}, 32'd0);
    checkOutput("rst_res_f",  res_f, 32'd0);
    for (int i = 0; i < 2; i++) begin
      m_state[i] = 0;
      m_out[i]   = 32'd0;
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // one operation: check result, done latency and single done pulse per instance
  task automatic runOp(input string tag, input logic [2:0] c, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] expv,
                       input int lat_e, input int lat_f, input bit repulse);
    int          first [2];
    int          cnt   [2];
    logic [31:0] rv    [2];
    for (int i = 0; i < 2; i++) begin
      first[i] = -1; cnt[i] = 0; rv[i] = 32'd0;
    end
    applyStimulus(1'b1, 1'b0, c, a, b);
    for (int k = 1; k <= 40; k++) begin
      if (repulse && k == 5) applyStimulus(1'b1, 1'b0, c, $urandom, $urandom);
      else                   applyStimulus(1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
      for (int i = 0; i < 2; i++) begin
        if (s_done[i]) begin
          cnt[i]++;
          if (first[i] < 0) begin
            first[i] = k;
            rv[i]    = s_res[i];
          end
        end
      end
    end
    checkOutput({tag, "_res_e"}, rv[0], expv);
    checkOutput({tag, "_lat_e"}, first[0], lat_e);
    checkOutput({tag, "_cnt_e"}, cnt[0], 32'd1);
    checkOutput({tag, "_res_f"}, rv[1], expv);
    checkOutput({tag, "_lat_f"}, first[1], lat_f);
    checkOutput({tag, "_cnt_f"}, cnt[1], 32'd1);
  endtask

  function automatic logic [31:0] pickOperand();
    case ($urandom_range(0, 7))
      0:       return 32'd0;
      1:       return 32'd1;
      2:       return 32'hFFFFFFFF;
      3:       return 32'h80000000;
      4:       return 32'h7FFFFFFF;
      5:       return $urandom_range(0, 15);
      default: return $urandom;
    endcase
  endfunction

  // directed cases, flush and re-pulse scenarios, random run, mid-op reset
  initial begin
    int dcnt;
    for (int i = 0; i < 2; i++) begin
      m_state[i] = 0; m_left[i] = 0; m_pend[i] = 32'd0; m_out[i] = 32'd0;
    end
    doReset();

    runOp("mul",      3'd0, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 33, 33, 1'b0);
    runOp("mulh",     3'd1, 32'h80000000, 32'h80000000, 32'h40000000, 33, 33, 1'b0);
    runOp("mulhsu",   3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 33, 33, 1'b0);
    runOp("mulhu",    3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33, 33, 1'b0);
    runOp("div",      3'd4, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33, 33, 1'b0);
    runOp("rem",      3'd6, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33, 33, 1'b0);
    runOp("divu",     3'd5, 32'hFFFFFFF9, 32'd2,        32'h7FFFFFFC, 33, 33, 1'b0);
    runOp("remu",     3'd7, 32'hFFFFFFF9, 32'd2,        32'd1,        33, 33, 1'b0);
    runOp("divu_z",   3'd5, 32'd5,        32'd0,        32'hFFFFFFFF, 1,  33, 1'b0);
    runOp("rem_z",    3'd6, 32'd5,        32'd0,        32'd5,        1,  33, 1'b0);
    runOp("div_z",    3'd4, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFFF, 1,  33, 1'b0);
    runOp("remu_z",   3'd7, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 1,  33, 1'b0);
    runOp("div_ovf",  3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1,  33, 1'b0);
    runOp("rem_ovf",  3'd6, 32'h80000000, 32'hFFFFFFFF, 32'd0,        1,  33, 1'b0);
    runOp("divu_rep", 3'd5, 32'd100,      32'd7,        32'd14,       33, 33, 1'b1);

    // DIV flushed ten cycles in: no done pulse, idle the cycle after the flush
    dcnt = 0;
    applyStimulus(1'b1, 1'b0, 3'd4, 32'd1000, 32'd3);
    for (int k = 1; k <= 11; k++) begin
      applyStimulus(1'b0, (k == 10), 3'd0, 32'd0, 32'd0);
      if (s_done[0] || s_done[1]) dcnt++;
    end
    checkOutput("flush_done", dcnt, 32'd0);
    checkOutput("flush_busy_e", {31'd0, s_busy[0]}, 32'd0);
    checkOutput("flush_busy_f", {31'd0, s_busy[1]}, 32'd0);
    runOp("mul_after_flush", 3'd0, 32'd3, 32'd4, 32'd12, 33, 33, 1'b0);

    for (int n = 0; n < 60000; n++) begin
      applyStimulus(($urandom_range(0, 3) == 0), ($urandom_range(0, 99) == 0),
                    3'($urandom_range(0, 7)), pickOperand(), pickOperand());
    end

    // reset in the middle of a multiply, then make sure the unit recovers
    applyStimulus(1'b1, 1'b0, 3'd0, 32'd5, 32'd6);
    for (int k = 0; k < 4; k++) applyStimulus(1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
    doReset();
    for (int k = 0; k < 40; k++) applyStimulus(1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
    runOp("mul_after_reset", 3'd0, 32'd5, 32'd6, 32'd30, 33, 33, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
